// File: rtl/qrs_window_search_if.sv
// Sample-stream and result bundle between the derivative front end,
// the QRS window search stage and the R-peak algorithm FSM.
interface qrs_window_search_if #(
    parameter int DATA_WIDTH = 11,
    parameter int CTR_WIDTH  = 24
);
    logic                         i_ce;
    logic signed [DATA_WIDTH-1:0] i_abs_diff;
    logic                         i_abs_diff_valid;
    logic [CTR_WIDTH-1:0]         i_ctr;
    logic                         i_search_en;
    logic [DATA_WIDTH-1:0]        i_threshold;
    logic signed [DATA_WIDTH-1:0] o_abs_diff_max;
    logic                         o_abs_diff_max_valid;
    logic                         o_extremum_found;
    logic [CTR_WIDTH-1:0]         o_extremum_ctr;
    logic                         o_busy;

    modport master (
        output i_ce, i_abs_diff, i_abs_diff_valid, i_ctr,
        output i_search_en, i_threshold,
        input  o_abs_diff_max, o_abs_diff_max_valid,
        input  o_extremum_found, o_extremum_ctr, o_busy
    );

    modport slave (
        input  i_ce, i_abs_diff, i_abs_diff_valid, i_ctr,
        input  i_search_en, i_threshold,
        output o_abs_diff_max, o_abs_diff_max_valid,
        output o_extremum_found, o_extremum_ctr, o_busy
    );
endinterface

// File: rtl/qrs_window_search.sv
// Threshold-triggered QRS window search: running max while idle, windowed
// max/index search once armed, one-cycle report, then refractory blanking.
module qrs_window_search #(
    parameter int DATA_WIDTH  = 11,
    parameter int CTR_WIDTH   = 24,
    parameter int WIN_LEN     = 36,
    parameter int REFRACT_LEN = 72
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    qrs_window_search_if.slave bus
);
    localparam int MAX_LEN = (WIN_LEN > REFRACT_LEN) ? WIN_LEN : REFRACT_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_LEN);
    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRACT_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_WINDOW,
        S_REPORT,
        S_REFRACT
    } state_t;

    state_t                       r_state;
    logic signed [DATA_WIDTH-1:0] r_max;
    logic                         r_max_vld;
    logic                         r_found;
    logic [CTR_WIDTH-1:0]         r_ext_ctr;
    logic signed [DATA_WIDTH-1:0] r_win_max;
    logic [CTR_WIDTH-1:0]         r_win_ctr;
    logic [CNT_W-1:0]             r_win_cnt;
    logic [CNT_W-1:0]             r_ref_cnt;

    logic                         w_acc;
    logic                         w_cross;
    logic                         w_run_gt;
    logic                         w_win_gt;
    logic signed [DATA_WIDTH-1:0] w_win_max;
    logic [CTR_WIDTH-1:0]         w_win_ctr;

    assign w_acc = bus.i_ce & bus.i_abs_diff_valid;

    // Threshold is unsigned, sample signed: widen both so negatives never cross.
    assign w_cross = $signed({bus.i_abs_diff[DATA_WIDTH-1], bus.i_abs_diff})
                   > $signed({1'b0, bus.i_threshold});

    assign w_run_gt  = bus.i_abs_diff > r_max;
    assign w_win_gt  = bus.i_abs_diff > r_win_max;
    assign w_win_max = w_win_gt ? bus.i_abs_diff : r_win_max;
    assign w_win_ctr = w_win_gt ? bus.i_ctr : r_win_ctr;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state   <= S_IDLE;
            r_max     <= '0;
            r_max_vld <= 1'b0;
            r_found   <= 1'b0;
            r_ext_ctr <= '0;
            r_win_max <= '0;
            r_win_ctr <= '0;
            r_win_cnt <= '0;
            r_ref_cnt <= '0;
        end else begin
            if (w_acc) begin
                r_max_vld <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_acc && w_run_gt) begin
                        r_max <= bus.i_abs_diff;
                    end
                    if (bus.i_search_en) begin
                        r_state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (!bus.i_search_en) begin
                        r_state <= S_IDLE;
                    end else if (w_acc && w_cross) begin
                        r_state   <= S_WINDOW;
                        r_win_max <= bus.i_abs_diff;
                        r_win_ctr <= bus.i_ctr;
                        r_win_cnt <= CNT_W'(1);
                    end
                end
                S_WINDOW: begin
                    if (w_acc) begin
                        r_win_max <= w_win_max;
                        r_win_ctr <= w_win_ctr;
                        r_win_cnt <= r_win_cnt + 1'b1;
                        // Closing sample is folded in before the result is latched.
                        if (r_win_cnt == WIN_LAST) begin
                            r_state   <= S_REPORT;
                            r_found   <= 1'b1;
                            r_max     <= w_win_max;
                            r_ext_ctr <= w_win_ctr;
                        end
                    end
                end
                S_REPORT: begin
                    r_found   <= 1'b0;
                    r_ref_cnt <= '0;
                    r_state   <= S_REFRACT;
                end
                S_REFRACT: begin
                    if (w_acc) begin
                        if (r_ref_cnt == REF_LAST) begin
                            if (bus.i_search_en) begin
                                r_state <= S_ARMED;
                            end else begin
                                r_state <= S_IDLE;
                                r_max   <= '0;
                            end
                        end else begin
                            r_ref_cnt <= r_ref_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_abs_diff_max       = r_max;
    assign bus.o_abs_diff_max_valid = r_max_vld;
    assign bus.o_extremum_found     = r_found;
    assign bus.o_extremum_ctr       = r_ext_ctr;
    assign bus.o_busy = (r_state == S_WINDOW) || (r_state == S_REPORT)
                     || (r_state == S_REFRACT);
endmodule

// File: tb/tb_qrs_window_search.sv
// Directed bench for qrs_window_search: vector table for the idle/search
// path plus hand sequences for refractory, stalls, enable drop and reset.
module tb_qrs_window_search;
    localparam int DW = 11;
    localparam int CW = 24;
    localparam int WL = 4;
    localparam int RL = 72;

    logic i_clk;
    logic i_nrst;
    int   n_tests;
    int   n_fail;

    qrs_window_search_if #(.DATA_WIDTH(DW), .CTR_WIDTH(CW)) bus ();

    qrs_window_search #(
        .DATA_WIDTH (DW),
        .CTR_WIDTH  (CW),
        .WIN_LEN    (WL),
        .REFRACT_LEN(RL)
    ) dut (
        .i_clk (i_clk),
        .i_nrst(i_nrst),
        .bus   (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic   ce;
        logic   vld;
        int     smp;
        int     ctr;
        logic   sen;
        int     thr;
        int     e_max;
        logic   e_vld;
        logic   e_found;
        int     e_ectr;
        logic   e_busy;
    } vec_t;

    vec_t vt[12];

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic ce, input logic vld, input int smp,
                         input int ctr, input logic sen, input int thr);
        bus.i_ce             = ce;
        bus.i_abs_diff_valid = vld;
        bus.i_abs_diff       = DW'(smp);
        bus.i_ctr            = CW'(ctr);
        bus.i_search_en      = sen;
        bus.i_threshold      = DW'(thr);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int smax();
        return int'(bus.o_abs_diff_max);
    endfunction

    initial begin
        int k_hit;
        n_tests = 0;
        n_fail  = 0;
        drive(0, 0, 0, 0, 0, 0);
        i_nrst = 1'b0;

        //       ce vld smp  ctr  sen thr  max vld fnd ectr busy
        vt[0]  = '{1, 1, 5,   0,   0, 0,   5,   1, 0, 0,   0};
        vt[1]  = '{1, 1, 40,  1,   0, 0,   40,  1, 0, 0,   0};
        vt[2]  = '{1, 1, -3,  2,   0, 0,   40,  1, 0, 0,   0};
        vt[3]  = '{1, 1, 12,  3,   0, 0,   40,  1, 0, 0,   0};
        vt[4]  = '{0, 0, 0,   4,   1, 100, 40,  1, 0, 0,   0};
        vt[5]  = '{1, 1, 100, 500, 1, 100, 40,  1, 0, 0,   0};
        vt[6]  = '{1, 1, 101, 501, 1, 100, 40,  1, 0, 0,   1};
        vt[7]  = '{1, 1, 150, 502, 1, 100, 40,  1, 0, 0,   1};
        vt[8]  = '{1, 1, 150, 503, 1, 100, 40,  1, 0, 0,   1};
        vt[9]  = '{1, 1, 90,  504, 1, 100, 40,  1, 0, 0,   1};
        vt[10] = '{1, 1, 20,  505, 1, 100, 150, 1, 1, 502, 1};
        vt[11] = '{0, 0, 0,   506, 1, 100, 150, 1, 0, 502, 1};

        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_max", smax(), 0);
        chk("rst_vld", int'(bus.o_abs_diff_max_valid), 0);
        chk("rst_found", int'(bus.o_extremum_found), 0);
        chk("rst_ectr", int'(bus.o_extremum_ctr), 0);
        chk("rst_busy", int'(bus.o_busy), 0);
        i_nrst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].ce, vt[i].vld, vt[i].smp, vt[i].ctr, vt[i].sen,
                  vt[i].thr);
            step();
            n_tests++;
            if (smax() != vt[i].e_max
                || bus.o_abs_diff_max_valid !== vt[i].e_vld
                || bus.o_extremum_found !== vt[i].e_found
                || int'(bus.o_extremum_ctr) != vt[i].e_ectr
                || bus.o_busy !== vt[i].e_busy) begin
                n_fail++;
                $display("FAIL vec%0d: max=%0d vld=%0b fnd=%0b ectr=%0d busy=%0b, expected max=%0d vld=%0b fnd=%0b ectr=%0d busy=%0b",
                         i, smax(), bus.o_abs_diff_max_valid,
                         bus.o_extremum_found, bus.o_extremum_ctr, bus.o_busy,
                         vt[i].e_max, vt[i].e_vld, vt[i].e_found,
                         vt[i].e_ectr, vt[i].e_busy);
            end
        end

        // Refractory: 72 crossing samples ignored, enable dropped for 2 clocks.
        for (int i = 0; i < RL; i++) begin
            drive(1, 1, 300, 510 + i, !(i == 30 || i == 31), 100);
            step();
            chk($sformatf("ref_found%0d", i), int'(bus.o_extremum_found), 0);
            chk($sformatf("ref_busy%0d", i), int'(bus.o_busy),
                (i == RL - 1) ? 0 : 1);
        end
        chk("ref_max", smax(), 150);

        // ARMED reached: next crossing opens a window.
        drive(1, 1, 300, 600, 1, 100);
        step();
        chk("rearm_busy", int'(bus.o_busy), 1);

        // i_ce low for 10 clocks mid-window delays the pulse by 10 clocks.
        k_hit = -1;
        for (int k = 1; k <= 40; k++) begin
            drive(!(k >= 2 && k <= 11), 1, 10, 600 + k, 1, 100);
            step();
            if (bus.o_extremum_found) begin
                k_hit = k;
                break;
            end
        end
        chk("stall_latency", k_hit, WL + 10);
        chk("stall_max", smax(), 300);
        chk("stall_ectr", int'(bus.o_extremum_ctr), 600);
        drive(0, 1, 0, 700, 1, 100);
        step();
        chk("stall_single_pulse", int'(bus.o_extremum_found), 0);

        for (int i = 0; i < RL; i++) begin
            drive(1, 1, 0, 700 + i, 1, 100);
            step();
        end
        chk("armed2_busy", int'(bus.o_busy), 0);

        // Enable drop wins over a same-cycle crossing.
        drive(1, 1, 200, 800, 0, 100);
        step();
        chk("drop_busy", int'(bus.o_busy), 0);
        chk("drop_max", smax(), 300);
        drive(1, 1, 400, 801, 0, 100);
        step();
        chk("idle_runmax", smax(), 400);
        chk("idle_busy", int'(bus.o_busy), 0);

        // Async reset in the middle of a window.
        drive(0, 0, 0, 802, 1, 100);
        step();
        drive(1, 1, 200, 803, 1, 100);
        step();
        chk("pre_rst_busy", int'(bus.o_busy), 1);
        i_nrst = 1'b0;
        #2;
        chk("arst_max", smax(), 0);
        chk("arst_vld", int'(bus.o_abs_diff_max_valid), 0);
        chk("arst_found", int'(bus.o_extremum_found), 0);
        chk("arst_ectr", int'(bus.o_extremum_ctr), 0);
        chk("arst_busy", int'(bus.o_busy), 0);
        step();
        i_nrst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 5, 900 + i, 0, 100);
            step();
            chk($sformatf("post_found%0d", i), int'(bus.o_extremum_found), 0);
            chk($sformatf("post_busy%0d", i), int'(bus.o_busy), 0);
        end
        chk("post_max", smax(), 5);
        chk("post_vld", int'(bus.o_abs_diff_max_valid), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
